// File: rtl/wsn_mem_map.sv
// Shared node-memory map for the neighbor table and the knownSinks list.
// Both the table writer and the best-hop reader import these constants.
package wsn_mem_map;

    localparam int WORD_WIDTH    = 16;
    localparam int NUM_NEIGHBORS = 64;
    localparam int NUM_SINKS     = 16;

    localparam logic [WORD_WIDTH-1:0] EMPTY_ID = 16'hFFFF;

    // Byte base addresses; each entry is one 16-bit word at stride 2.
    localparam logic [WORD_WIDTH-1:0] SINK_BASE    = 16'h0008;
    localparam logic [WORD_WIDTH-1:0] NBR_ID_BASE  = 16'h0048;
    localparam logic [WORD_WIDTH-1:0] CLUSTER_BASE = 16'h00C8;
    localparam logic [WORD_WIDTH-1:0] BATT_BASE    = 16'h0148;
    localparam logic [WORD_WIDTH-1:0] QVAL_BASE    = 16'h01C8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEARCH,
        S_WR_ID,
        S_WR_CLUSTER,
        S_WR_BATT,
        S_WR_QVAL,
        S_SINK_SEARCH,
        S_WR_SINK,
        S_DONE
    } ntw_state_t;

    // Byte address of word idx in the array starting at base.
    function automatic logic [WORD_WIDTH-1:0] word_addr(
        input logic [WORD_WIDTH-1:0] base,
        input logic [WORD_WIDTH-1:0] idx
    );
        return base + (idx << 1);
    endfunction

endpackage

// File: rtl/id_slot_scanner.sv
// Linear scanner over an array of 16-bit IDs. One entry is compared per
// cycle; it reports a key hit and remembers the first empty entry seen.
// Time-shared between the neighbor scan and the knownSinks scan.
module id_slot_scanner
    import wsn_mem_map::*;
#(
    parameter int                    IDX_W     = 6,
    parameter logic [WORD_WIDTH-1:0] EMPTY_KEY = 16'hFFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_step,
    input  logic [WORD_WIDTH-1:0] i_base,
    input  logic [WORD_WIDTH-1:0] i_key,
    input  logic [WORD_WIDTH-1:0] i_data,
    input  logic [IDX_W-1:0]      i_last,
    output logic                  o_hit,
    output logic                  o_last,
    output logic                  o_free_found,
    output logic [IDX_W-1:0]      o_idx,
    output logic [IDX_W-1:0]      o_free_idx,
    output logic [WORD_WIDTH-1:0] o_next_addr
);

    logic [IDX_W-1:0]      r_idx;
    logic                  r_free_found;
    logic [IDX_W-1:0]      r_free_idx;
    logic                  w_empty;
    logic [WORD_WIDTH-1:0] w_next_off;

    // Index and first-free tracking; start clears, step advances one entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx        <= '0;
            r_free_found <= 1'b0;
            r_free_idx   <= '0;
        end else if (i_start) begin
            r_idx        <= '0;
            r_free_found <= 1'b0;
            r_free_idx   <= '0;
        end else if (i_step) begin
            r_idx <= r_idx + 1'b1;
            if (!r_free_found && w_empty) begin
                r_free_found <= 1'b1;
                r_free_idx   <= r_idx;
            end
        end
    end

    // Current-entry compare; free status already includes this entry so the
    // caller can decide on the last entry without an extra cycle.
    always_comb begin
        w_empty      = (i_data == EMPTY_KEY);
        o_hit        = (i_data == i_key);
        o_last       = (r_idx == i_last);
        o_idx        = r_idx;
        o_free_found = r_free_found | w_empty;
        o_free_idx   = r_free_found ? r_free_idx : r_idx;
        w_next_off   = WORD_WIDTH'(r_idx) + 16'd1;
        o_next_addr  = i_base + (w_next_off << 1);
    end

endmodule

// File: rtl/neighbor_table_writer.sv
// Write-side agent for the neighbor table: finds or allocates the slot for
// one decoded beacon, writes its four words, and records sink senders in
// the knownSinks list.
module neighbor_table_writer #(
    parameter int          NUM_NEIGHBORS = wsn_mem_map::NUM_NEIGHBORS,
    parameter int          NUM_SINKS     = wsn_mem_map::NUM_SINKS,
    parameter logic [15:0] EMPTY_ID      = wsn_mem_map::EMPTY_ID,
    localparam int         IDX_W         = $clog2(NUM_NEIGHBORS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      src_id,
    input  logic [15:0]      src_cluster,
    input  logic [15:0]      src_battery,
    input  logic [15:0]      src_qvalue,
    input  logic             src_is_sink,
    output logic [15:0]      address,
    input  logic [15:0]      data_in,
    output logic [15:0]      data_out,
    output logic             wr_en,
    output logic             done,
    output logic [IDX_W-1:0] slot,
    output logic             new_neighbor,
    output logic             table_full
);

    import wsn_mem_map::*;

    ntw_state_t       r_state;
    logic [15:0]      r_address;
    logic [15:0]      r_data_out;
    logic             r_wr_en;
    logic             r_done;
    logic             r_in_ready;
    logic [IDX_W-1:0] r_slot;
    logic             r_new;
    logic             r_full;

    logic [15:0]      r_id;
    logic [15:0]      r_cluster;
    logic [15:0]      r_batt;
    logic [15:0]      r_qval;
    logic             r_is_sink;

    logic             w_accept;
    logic             w_sink_phase;
    logic             w_scan_start;
    logic             w_scan_step;
    logic [15:0]      w_scan_base;
    logic [IDX_W-1:0] w_scan_last;
    logic             w_hit;
    logic             w_last;
    logic             w_free_found;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_free_idx;
    logic [15:0]      w_next_addr;

    // Scanner control: the single scanner serves the neighbor scan, then the
    // sink scan once the neighbor words are written.
    always_comb begin
        w_accept     = (r_state == S_IDLE) && in_valid;
        w_sink_phase = (r_state == S_SINK_SEARCH);
        w_scan_start = w_accept || ((r_state == S_WR_QVAL) && r_is_sink);
        w_scan_step  = (r_state == S_SEARCH) || w_sink_phase;
        w_scan_base  = w_sink_phase ? SINK_BASE : NBR_ID_BASE;
        w_scan_last  = w_sink_phase ? IDX_W'(NUM_SINKS - 1) : IDX_W'(NUM_NEIGHBORS - 1);
    end

    id_slot_scanner #(
        .IDX_W     (IDX_W),
        .EMPTY_KEY (EMPTY_ID)
    ) u_scanner (
        .clock        (clock),
        .reset        (reset),
        .i_start      (w_scan_start),
        .i_step       (w_scan_step),
        .i_base       (w_scan_base),
        .i_key        (r_id),
        .i_data       (data_in),
        .i_last       (w_scan_last),
        .o_hit        (w_hit),
        .o_last       (w_last),
        .o_free_found (w_free_found),
        .o_idx        (w_idx),
        .o_free_idx   (w_free_idx),
        .o_next_addr  (w_next_addr)
    );

    // Beacon fields are captured on accept and held for the whole update.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_id      <= src_id;
            r_cluster <= src_cluster;
            r_batt    <= src_battery;
            r_qval    <= src_qvalue;
            r_is_sink <= src_is_sink;
        end
    end

    // Update sequencer; every memory-facing output is registered and set up
    // on the transition into the state that uses it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_address  <= NBR_ID_BASE;
            r_data_out <= '0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b1;
            r_slot     <= '0;
            r_new      <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state    <= S_SEARCH;
                        r_in_ready <= 1'b0;
                        r_address  <= NBR_ID_BASE;
                        r_slot     <= '0;
                        r_new      <= 1'b0;
                        r_full     <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (w_hit) begin
                        // Existing neighbor: its ID word is already correct.
                        r_slot     <= w_idx;
                        r_new      <= 1'b0;
                        r_address  <= word_addr(CLUSTER_BASE, 16'(w_idx));
                        r_data_out <= r_cluster;
                        r_wr_en    <= 1'b1;
                        r_state    <= S_WR_CLUSTER;
                    end else if (w_last) begin
                        if (w_free_found) begin
                            r_slot     <= w_free_idx;
                            r_new      <= 1'b1;
                            r_address  <= word_addr(NBR_ID_BASE, 16'(w_free_idx));
                            r_data_out <= r_id;
                            r_wr_en    <= 1'b1;
                            r_state    <= S_WR_ID;
                        end else begin
                            r_full  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_address <= w_next_addr;
                    end
                end
                S_WR_ID: begin
                    r_address  <= word_addr(CLUSTER_BASE, 16'(r_slot));
                    r_data_out <= r_cluster;
                    r_state    <= S_WR_CLUSTER;
                end
                S_WR_CLUSTER: begin
                    r_address  <= word_addr(BATT_BASE, 16'(r_slot));
                    r_data_out <= r_batt;
                    r_state    <= S_WR_BATT;
                end
                S_WR_BATT: begin
                    r_address  <= word_addr(QVAL_BASE, 16'(r_slot));
                    r_data_out <= r_qval;
                    r_state    <= S_WR_QVAL;
                end
                S_WR_QVAL: begin
                    r_wr_en <= 1'b0;
                    if (r_is_sink) begin
                        r_address <= SINK_BASE;
                        r_state   <= S_SINK_SEARCH;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_SINK_SEARCH: begin
                    if (w_hit) begin
                        // Sink already known: nothing to record.
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_last) begin
                        if (w_free_found) begin
                            r_address  <= word_addr(SINK_BASE, 16'(w_free_idx));
                            r_data_out <= r_id;
                            r_wr_en    <= 1'b1;
                            r_state    <= S_WR_SINK;
                        end else begin
                            // List full: the sink is silently not recorded.
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_address <= w_next_addr;
                    end
                end
                S_WR_SINK: begin
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_wr_en    <= 1'b0;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Registered state drives the ports directly.
    always_comb begin
        in_ready     = r_in_ready;
        address      = r_address;
        data_out     = r_data_out;
        wr_en        = r_wr_en;
        done         = r_done;
        slot         = r_slot;
        new_neighbor = r_new;
        table_full   = r_full;
    end

endmodule

// File: tb/tb_neighbor_table_writer.sv
// Directed bench for neighbor_table_writer with a behavioral node memory.
module tb_neighbor_table_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] src_id, src_cluster, src_battery, src_qvalue;
    logic        src_is_sink;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        wr_en;
    logic        done;
    logic [5:0]  slot;
    logic        new_neighbor;
    logic        table_full;

    logic [15:0] mem [0:511];
    logic        pk_en;
    logic [15:0] pk_addr, pk_data;
    logic [31:0] nwr  = 0;
    logic [31:0] nacc = 0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    neighbor_table_writer dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .src_id       (src_id),
        .src_cluster  (src_cluster),
        .src_battery  (src_battery),
        .src_qvalue   (src_qvalue),
        .src_is_sink  (src_is_sink),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .wr_en        (wr_en),
        .done         (done),
        .slot         (slot),
        .new_neighbor (new_neighbor),
        .table_full   (table_full)
    );

    assign data_in = mem[address[9:1]];

    always @(posedge clock) begin
        if (wr_en) begin
            mem[address[9:1]] <= data_out;
            nwr <= nwr + 1;
        end else if (pk_en) begin
            mem[pk_addr[9:1]] <= pk_data;
        end
        if (in_valid && in_ready) nacc <= nacc + 1;
    end

    typedef struct {
        logic [1:0]  base_mode;   // 0 all empty, 1 IDs 0..63, 2 keep
        int          a_slot;
        logic [15:0] a_val;
        int          b_slot;
        logic [15:0] b_val;
        int          n_sinks;     // -1 keeps knownSinks as is
        logic [15:0] id, cl, bt, qv;
        logic        sink;
        int          exp_lat;
        int          exp_slot;
        logic        exp_new;
        logic        exp_full;
        int          exp_wr;
        int          exp_sink_idx;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pk_addr = a;
        pk_data = d;
        pk_en   = 1'b1;
        @(posedge clock); #1;
        pk_en   = 1'b0;
    endtask

    task automatic setup(input vec_t v);
        if (v.base_mode != 2'd2) begin
            for (int n = 0; n < 64; n++) begin
                poke(16'h0048 + 16'(2 * n), (v.base_mode == 2'd1) ? 16'(n) : 16'hFFFF);
                poke(16'h00C8 + 16'(2 * n), 16'h0000);
                poke(16'h0148 + 16'(2 * n), 16'h0000);
                poke(16'h01C8 + 16'(2 * n), 16'h0000);
            end
        end
        if (v.a_slot >= 0) poke(16'h0048 + 16'(2 * v.a_slot), v.a_val);
        if (v.b_slot >= 0) poke(16'h0048 + 16'(2 * v.b_slot), v.b_val);
        if (v.n_sinks >= 0) begin
            for (int k = 0; k < 16; k++)
                poke(16'h0008 + 16'(2 * k), (k < v.n_sinks) ? 16'h1000 + 16'(k) : 16'hFFFF);
        end
    endtask

    task automatic run_beacon(input logic [15:0] id, cl, bt, qv, input logic sk, output int lat);
        int cyc;
        @(posedge clock); #1;
        src_id = id; src_cluster = cl; src_battery = bt; src_qvalue = qv; src_is_sink = sk;
        in_valid = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clock); #1;
            cyc++;
        end
        lat = cyc;
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem[a[9:1]];
    endfunction

    initial begin
        int lat;
        int cyc;
        int dn, rdy;
        logic [31:0] w0, a0;
        logic        saw_busy_ready;

        vt[0] = '{2'd0, -1, 16'h0, -1, 16'h0, 0, 16'h0005, 16'h0003, 16'h4000, 16'h3800, 1'b0, 69, 0, 1'b1, 1'b0, 4, -1};
        vt[1] = '{2'd0, 10, 16'h0005, -1, 16'h0, 0, 16'h0005, 16'h0003, 16'h4400, 16'h3C00, 1'b0, 15, 10, 1'b0, 1'b0, 3, -1};
        vt[2] = '{2'd1, -1, 16'h0, -1, 16'h0, 0, 16'h0100, 16'h0001, 16'h0002, 16'h0003, 1'b0, 65, 0, 1'b0, 1'b1, 0, -1};
        vt[3] = '{2'd0, -1, 16'h0, -1, 16'h0, 3, 16'h0007, 16'h0002, 16'h4200, 16'h3A00, 1'b1, 86, 0, 1'b1, 1'b0, 5, 3};
        vt[4] = '{2'd2, -1, 16'h0, -1, 16'h0, -1, 16'h0007, 16'h0002, 16'h4300, 16'h3B00, 1'b1, 9, 0, 1'b0, 1'b0, 3, -1};
        vt[5] = '{2'd0, 4, 16'h0009, 20, 16'h0009, 0, 16'h0009, 16'h0011, 16'h4500, 16'h3D00, 1'b0, 9, 4, 1'b0, 1'b0, 3, -1};
        vt[6] = '{2'd1, 30, 16'hFFFF, 50, 16'hFFFF, 0, 16'h0200, 16'h0022, 16'h4600, 16'h3E00, 1'b0, 69, 30, 1'b1, 1'b0, 4, -1};
        vt[7] = '{2'd0, -1, 16'h0, -1, 16'h0, 16, 16'h0008, 16'h0033, 16'h4700, 16'h3F00, 1'b1, 85, 0, 1'b1, 1'b0, 4, -1};
        vt[8] = '{2'd1, -1, 16'h0, -1, 16'h0, 0, 16'h003F, 16'h0044, 16'h4800, 16'h4000, 1'b0, 68, 63, 1'b0, 1'b0, 3, -1};
        vt[9] = '{2'd1, -1, 16'h0, -1, 16'h0, 0, 16'h0000, 16'h0055, 16'h4900, 16'h4100, 1'b0, 5, 0, 1'b0, 1'b0, 3, -1};

        reset = 1'b1; in_valid = 1'b0; pk_en = 1'b0; pk_addr = '0; pk_data = '0;
        src_id = '0; src_cluster = '0; src_battery = '0; src_qvalue = '0; src_is_sink = 1'b0;
        #12;
        chk("rst_address", 32'(address), 32'h0048);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_slot", 32'(slot), 32'd0);
        chk("rst_new", 32'(new_neighbor), 32'd0);
        chk("rst_full", 32'(table_full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock); reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            setup(vt[i]);
            w0 = nwr;
            run_beacon(vt[i].id, vt[i].cl, vt[i].bt, vt[i].qv, vt[i].sink, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("v%0d_slot", i), 32'(slot), 32'(vt[i].exp_slot));
            chk($sformatf("v%0d_new", i), 32'(new_neighbor), 32'(vt[i].exp_new));
            chk($sformatf("v%0d_full", i), 32'(table_full), 32'(vt[i].exp_full));
            chk($sformatf("v%0d_writes", i), nwr - w0, 32'(vt[i].exp_wr));
            if (!vt[i].exp_full) begin
                chk($sformatf("v%0d_id_word", i), 32'(rd(16'h0048 + 16'(2 * vt[i].exp_slot))), 32'(vt[i].id));
                chk($sformatf("v%0d_cl_word", i), 32'(rd(16'h00C8 + 16'(2 * vt[i].exp_slot))), 32'(vt[i].cl));
                chk($sformatf("v%0d_bt_word", i), 32'(rd(16'h0148 + 16'(2 * vt[i].exp_slot))), 32'(vt[i].bt));
                chk($sformatf("v%0d_qv_word", i), 32'(rd(16'h01C8 + 16'(2 * vt[i].exp_slot))), 32'(vt[i].qv));
            end
            if (vt[i].exp_sink_idx >= 0)
                chk($sformatf("v%0d_sink_word", i), 32'(rd(16'h0008 + 16'(2 * vt[i].exp_sink_idx))), 32'(vt[i].id));
            @(posedge clock); #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_ready_after", i), 32'(in_ready), 32'd1);
        end

        // Reset while the battery word is on the bus.
        setup(vt[0]);
        @(posedge clock); #1;
        src_id = 16'h0011; src_cluster = 16'h0022; src_battery = 16'h0033; src_qvalue = 16'h0044;
        src_is_sink = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!(wr_en && address == 16'h0148) && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("rst_mid_reached_batt_cycle", 32'(cyc), 32'd67);
        reset = 1'b1;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_address", 32'(address), 32'h0048);
        @(negedge clock); reset = 1'b0;
        chk("rst_mid_id_kept", 32'(rd(16'h0048)), 32'h0011);
        chk("rst_mid_cl_kept", 32'(rd(16'h00C8)), 32'h0022);
        chk("rst_mid_bt_unwritten", 32'(rd(16'h0148)), 32'h0000);
        w0 = nwr;
        run_beacon(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, lat);
        chk("rst_next_latency", 32'(lat), 32'd5);
        chk("rst_next_slot", 32'(slot), 32'd0);
        chk("rst_next_new", 32'(new_neighbor), 32'd0);
        chk("rst_next_writes", nwr - w0, 32'd3);
        chk("rst_next_bt", 32'(rd(16'h0148)), 32'h0033);

        // in_valid held high across two complete updates.
        setup('{2'd0, 0, 16'h0055, -1, 16'h0, 0, 16'h0055, 16'h0066, 16'h0077, 16'h0088, 1'b0, 0, 0, 1'b0, 1'b0, 0, -1});
        @(posedge clock); #1;
        src_id = 16'h0055; src_cluster = 16'h0066; src_battery = 16'h0077; src_qvalue = 16'h0088;
        src_is_sink = 1'b0; in_valid = 1'b1;
        w0 = nwr; a0 = nacc;
        @(posedge clock); #1;
        dn = 0; rdy = 0; saw_busy_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) begin
                @(posedge clock); #1;
            end
            if (done) dn++;
            if (in_ready) begin
                rdy++;
                if (k != 6 && k != 12) saw_busy_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("hold_done_count", 32'(dn), 32'd2);
        chk("hold_ready_count", 32'(rdy), 32'd2);
        chk("hold_ready_low_busy", 32'(saw_busy_ready), 32'd0);
        chk("hold_accepts", nacc - a0, 32'd2);
        chk("hold_writes", nwr - w0, 32'd6);
        @(posedge clock); #1;
        chk("hold_idle_ready", 32'(in_ready), 32'd1);
        chk("hold_idle_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
